// File: rtl/io_uart_tx.sv
// Purpose: memory-mapped UART transmitter (TXDATA/STATUS/CTRL) with byte FIFO and 8N1 serializer.
// Latency: register reads return one cycle after the strobe; a byte leaves START one cycle after it lands in an idle FIFO.
// Backpressure: none on the IO bus; TXDATA writes to a full FIFO (with no same-cycle pop) are dropped and flag overflow.
//
// Ports:
//   clk, resetb                      single clock, asynchronous active-low reset
//   io_addr/io_en/io_we/io_data_write  core IO access (one-cycle strobe)
//   io_data_read                     registered read data, zero when not returning a read
//   uart_tx                          registered serial line, idle high
//   irq_uart                         registered level interrupt: transmitter drained

// Generic single-clock FIFO, valid/ready on both sides.
// Zero-latency status; out_dat is the head entry whenever out_vld is high.
// in_rdy stays high when full if the head is popped in the same cycle.
module io_uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign out_vld = ~empty;
    assign out_dat = mem_q[rd_ptr_q];
    assign pop     = out_rdy & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign in_rdy  = ~full | pop;
    assign push    = in_vld & in_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_dat;
    end
endmodule

module io_uart_tx #(
    parameter logic [7:0]  BASE_ADDR  = 8'h10,
    parameter logic [15:0] CLK_DIV    = 16'd434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    output logic        uart_tx,
    output logic        irq_uart
);
    localparam logic [7:0]  ADDR_TXDATA = BASE_ADDR;
    localparam logic [7:0]  ADDR_STATUS = BASE_ADDR + 8'd4;
    localparam logic [7:0]  ADDR_CTRL   = BASE_ADDR + 8'd8;
    localparam logic [15:0] BIT_RELOAD  = CLK_DIV - 16'd1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic        overflow_q, overflow_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_txdata, wr_ctrl, rd_status, rd_ctrl;
    logic        fifo_in_rdy, fifo_vld, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]  fifo_dat;
    logic        busy, bit_end, ovf_evt;
    logic [4:0]  status;
    logic        unused_wdata;

    assign unused_wdata = ^io_data_write[31:8];

    // Address decode; a TXDATA read selects the register but returns zero.
    assign wr_txdata = io_en &  io_we & (io_addr == ADDR_TXDATA);
    assign wr_ctrl   = io_en &  io_we & (io_addr == ADDR_CTRL);
    assign rd_status = io_en & ~io_we & (io_addr == ADDR_STATUS);
    assign rd_ctrl   = io_en & ~io_we & (io_addr == ADDR_CTRL);

    io_uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetb  (resetb),
        .in_vld  (wr_txdata),
        .in_rdy  (fifo_in_rdy),
        .in_dat  (io_data_write[7:0]),
        .out_vld (fifo_vld),
        .out_rdy (fifo_pop),
        .out_dat (fifo_dat),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign busy    = (state_q != S_IDLE);
    assign bit_end = (cnt_q == 16'd0);
    assign ovf_evt = wr_txdata & ~fifo_in_rdy;
    assign status  = {overflow_q, busy, fifo_empty, fifo_full, irq_en_q};

    // Serializer: cnt counts down through each bit period and reloads on every bit boundary.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fifo_vld) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dat;
                    cnt_d    = BIT_RELOAD;
                    tx_d     = 1'b0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = BIT_RELOAD;
                    idx_d   = 3'd0;
                    tx_d    = shreg_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = BIT_RELOAD;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d = shreg_q[idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame when more data is queued.
                    if (fifo_vld) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_dat;
                        cnt_d    = BIT_RELOAD;
                        tx_d     = 1'b0;
                        state_d  = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Register file, interrupt and read data path.
    always_comb begin
        // A same-cycle overflow outranks the read-to-clear.
        overflow_d = ovf_evt ? 1'b1 : (rd_status ? 1'b0 : overflow_q);
        irq_en_d   = wr_ctrl ? io_data_write[0] : irq_en_q;
        irq_d      = irq_en_q & fifo_empty & ~busy;
        rdata_d    = 32'h0;
        if (rd_status) rdata_d = {27'b0, status};
        if (rd_ctrl)   rdata_d = {31'b0, irq_en_q};
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            idx_q      <= 3'd0;
            shreg_q    <= 8'd0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

    assign uart_tx      = tx_q;
    assign irq_uart     = irq_q;
    assign io_data_read = rdata_q;
endmodule

// File: tb/tb_io_uart_tx.sv
// Purpose: directed testbench for io_uart_tx (CLK_DIV=4, BASE_ADDR=8'h10).
// Latency: inputs change just after falling edges; outputs are sampled on falling edges.
// Backpressure: not applicable; each task owns the bus for the cycles it drives.
module tb_io_uart_tx;
    logic        clk;
    logic        resetb;
    logic [7:0]  io_addr;
    logic        io_en;
    logic        io_we;
    logic [31:0] io_data_write;
    logic [31:0] io_data_read;
    logic        uart_tx;
    logic        irq_uart;

    int errors;
    int checks;

    io_uart_tx #(
        .BASE_ADDR  (8'h10),
        .CLK_DIV    (16'd4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .resetb        (resetb),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .uart_tx       (uart_tx),
        .irq_uart      (irq_uart)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tasks are entered just after a falling edge and return just after one.
    task automatic io_write(input logic [7:0] addr, input logic [31:0] data);
        io_addr       = addr;
        io_data_write = data;
        io_we         = 1'b1;
        io_en         = 1'b1;
        @(negedge clk);
        io_en = 1'b0;
        io_we = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] addr, output logic [31:0] data);
        io_addr = addr;
        io_we   = 1'b0;
        io_en   = 1'b1;
        @(negedge clk);
        io_en = 1'b0;
        data  = io_data_read;
    endtask

    // Expects START to be on the line now or after one more cycle, then checks all 40 cycles.
    task automatic check_frame(input logic [7:0] b, input bit chk_irq);
        logic       exp;
        logic [2:0] bi;
        if (uart_tx === 1'b1) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            bi = 3'((i - 4) / 4);
            if (i < 4)       exp = 1'b0;
            else if (i >= 36) exp = 1'b1;
            else              exp = b[bi];
            checks++;
            if (uart_tx !== exp) begin
                errors++;
                $display("FAIL frame_%h_cycle%0d uart_tx got %b want %b", b, i, uart_tx, exp);
            end
            if (chk_irq) begin
                checks++;
                if (irq_uart !== 1'b0) begin
                    errors++;
                    $display("FAIL irq_during_frame cycle%0d got %b want 0", i, irq_uart);
                end
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        resetb        = 1'b0;
        io_en         = 1'b0;
        io_we         = 1'b0;
        io_addr       = 8'h00;
        io_data_write = 32'h0;
        #12;
        checks++;
        if ({uart_tx, irq_uart, io_data_read} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs got tx=%b irq=%b rd=%h want tx=1 irq=0 rd=0", uart_tx, irq_uart, io_data_read);
        end
        @(negedge clk);
        resetb = 1'b1;
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL reset_status got %h want 00000004", d);
        end
        io_read(8'h18, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl got %h want 00000000", d);
        end
    endtask

    task automatic test_single_frame;
        logic [31:0] d;
        io_write(8'h10, 32'hFFFF_FFA5);
        check_frame(8'hA5, 1'b0);
        @(negedge clk);
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL frame_done_status got %h want 00000004", d);
        end
    endtask

    task automatic test_read_decode;
        logic [31:0] d;
        int lows;
        io_write(8'h18, 32'hFFFF_FFFF);
        io_read(8'h18, d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL ctrl_read got %h want 00000001", d);
        end
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h5) begin
            errors++;
            $display("FAIL status_read got %h want 00000005", d);
        end
        @(negedge clk);
        checks++;
        if (io_data_read !== 32'h0) begin
            errors++;
            $display("FAIL status_read_one_cycle got %h want 00000000", io_data_read);
        end
        io_read(8'h10, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read got %h want 00000000", d);
        end
        io_read(8'h20, d);
        @(negedge clk);
        checks++;
        if ({d, io_data_read} !== 64'h0) begin
            errors++;
            $display("FAIL unmapped_read got %h then %h want 0 then 0", d, io_data_read);
        end
        // A write with io_en low or to an unmapped address must not start a frame.
        io_addr = 8'h10; io_we = 1'b1; io_data_write = 32'h55; io_en = 1'b0;
        @(negedge clk);
        io_we = 1'b0;
        io_write(8'h0C, 32'h55);
        io_write(8'h14, 32'h55);
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL ignored_writes uart_tx low cycles got %0d want 0", lows);
        end
        io_write(8'h18, 32'h0);
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL decode_status got %h want 00000004", d);
        end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) io_write(8'h10, 32'h11 + i);
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h0A) begin
            errors++;
            $display("FAIL fifo_full_status got %h want 0000000a", d);
        end
        io_write(8'h10, 32'h99);
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h1A) begin
            errors++;
            $display("FAIL overflow_status got %h want 0000001a", d);
        end
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h0A) begin
            errors++;
            $display("FAIL overflow_cleared got %h want 0000000a", d);
        end
        repeat (205) @(negedge clk);
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL drain_status got %h want 00000004", d);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        io_write(8'h10, 32'h3C);
        io_write(8'h10, 32'hC3);
        check_frame(8'h3C, 1'b0);
        check_frame(8'hC3, 1'b0);
        @(negedge clk);
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL b2b_status got %h want 00000004", d);
        end
    endtask

    task automatic test_irq;
        io_write(8'h18, 32'h1);
        io_write(8'h10, 32'h5A);
        checks++;
        if (irq_uart !== 1'b1) begin
            errors++;
            $display("FAIL irq_idle_enabled got %b want 1", irq_uart);
        end
        check_frame(8'h5A, 1'b1);
        @(negedge clk);
        checks++;
        if (irq_uart !== 1'b0) begin
            errors++;
            $display("FAIL irq_at_stop_end got %b want 0", irq_uart);
        end
        @(negedge clk);
        checks++;
        if (irq_uart !== 1'b1) begin
            errors++;
            $display("FAIL irq_after_stop got %b want 1", irq_uart);
        end
        io_write(8'h18, 32'h0);
        checks++;
        if (irq_uart !== 1'b1) begin
            errors++;
            $display("FAIL irq_registered_lag got %b want 1", irq_uart);
        end
        @(negedge clk);
        checks++;
        if (irq_uart !== 1'b0) begin
            errors++;
            $display("FAIL irq_disabled got %b want 0", irq_uart);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] d;
        int lows;
        io_write(8'h10, 32'hA5);
        repeat (18) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL data_bit3_before_reset got %b want 0", uart_tx);
        end
        #2 resetb = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_tx got %b want 1", uart_tx);
        end
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
        lows = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            errors++;
            $display("FAIL no_resume low cycles got %0d want 0", lows);
        end
        io_read(8'h14, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL post_reset_status got %h want 00000004", d);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_frame();
        test_read_decode();
        test_overflow();
        test_back_to_back();
        test_irq();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 8'h10, meaning the io_addr of the TXDATA register; STATUS is at BASE_ADDR+4 and CTRL at BASE_ADDR+8.
REQ-002 SHALL provide parameter CLK_DIV, default 16'd434, meaning clk cycles per serial bit (legal range >= 2).
REQ-003 SHALL provide parameter FIFO_DEPTH, default 4, meaning TX byte FIFO entries (power of two).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-005 SHALL have port resetb, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port io_addr, input, 8, meaning the IO register address from the core.
REQ-007 SHALL have port io_en, input, 1, meaning the IO access strobe, one cycle per access.
REQ-008 SHALL have port io_we, input, 1, meaning write (1) or read (0), qualified by io_en.
REQ-009 SHALL have port io_data_write, input, 32, meaning the write data.
REQ-010 SHALL have port io_data_read, output, 32, meaning the registered read data.
REQ-011 SHALL have port uart_tx, output, 1, meaning the serial line, idle high.
REQ-012 SHALL have port irq_uart, output, 1, meaning the level interrupt "transmitter drained".

Function
REQ-013 SHALL treat an access as selected only when io_en=1 and io_addr equals one of the three register addresses; all other accesses SHALL be ignored.
REQ-014 SHALL, on a TXDATA write, push io_data_write[7:0] into the FIFO if not full; if full, SHALL drop the byte and set the sticky overflow flag.
REQ-015 SHALL, on a CTRL write, load bit0 into irq_en; other bits SHALL be ignored.
REQ-016 SHALL present read data on io_data_read exactly one cycle after the read strobe, and SHALL drive 32'h0 in every other cycle.
REQ-017 SHALL return STATUS as {27'b0, overflow, busy, fifo_empty, fifo_full, irq_en}, bit0=irq_en.
REQ-018 SHALL return CTRL as {31'b0, irq_en}; a TXDATA read SHALL return 32'h0.
REQ-019 SHALL clear overflow on a STATUS read; an overflow event in that same cycle SHALL win and leave the flag set.
REQ-020 SHALL implement the serializer FSM with states IDLE, START, DATA, STOP; busy=1 in any state except IDLE.
REQ-021 SHALL, in IDLE with the FIFO non-empty, pop one byte and enter START on the next edge.
REQ-022 SHALL hold each of START (uart_tx=0), DATA (8 bits, LSB first) and STOP (uart_tx=1) for exactly CLK_DIV cycles per bit, for a frame of 10*CLK_DIV cycles.
REQ-023 SHALL use a bit-period counter that reloads at the start of every bit, and a 3-bit index that wraps 7->0 on the transition DATA->STOP.
REQ-024 SHALL, at the end of STOP, go to START directly if the FIFO is non-empty (no idle gap), else go to IDLE.
REQ-025 SHALL, on a simultaneous push and pop, keep the count unchanged; a push to a full FIFO with a same-cycle pop SHALL be accepted.
REQ-026 SHALL drive irq_uart = irq_en & fifo_empty & ~busy, registered, so it updates one cycle after its terms change.
REQ-027 SHALL drive uart_tx from a register, with no combinational path from any input.

Reset
REQ-028 SHALL, while resetb=0, force: FSM=IDLE, FIFO empty, pointers=0, overflow=0, irq_en=0, uart_tx=1, io_data_read=0, irq_uart=0.
REQ-029 SHALL, when reset asserts mid-frame, abort the frame immediately, with uart_tx going high asynchronously; on release, no partial frame SHALL resume.

Verification (CLK_DIV=4, BASE_ADDR=8'h10)
REQ-030 SHALL cover: write 8'hA5 to 8'h10 -> uart_tx low 4 cycles, then 1,0,1,0,0,1,0,1 each for 4 cycles, then high 4 cycles; busy=0 after 40 cycles.
REQ-031 SHALL cover: 5 back-to-back TXDATA writes while idle -> the first byte is popped, so 4 bytes are queued and overflow=0; a 6th write -> STATUS read returns bit4=1, and a second read returns bit4=0.
REQ-032 SHALL cover: write CTRL=1, then one byte -> irq_uart=0 while sending, and 1 one cycle after STOP ends; write CTRL=0 -> irq_uart=0 the next cycle.
REQ-033 SHALL cover: two queued bytes -> the second START follows the first STOP with no gap (20 consecutive bit periods).
REQ-034 SHALL cover: resetb pulsed low in DATA bit 3 -> uart_tx=1 immediately, STATUS reads 32'h4 after release.
REQ-035 SHALL cover: read to 8'h14 with io_en=1 -> value present the next cycle only; a read to the unmapped 8'h20 -> io_data_read stays 0.
